spell_rambus_arbiter: RTL and testbench
=======================================

// Module: spell_rambus_arbiter
// PURPOSE
//  Two-master to one-slave Wishbone classic arbiter for the spell RAM bus.
//  M0 is the spell core rambus master. M1 is the host window from the Caravel wishbone.
//  S is the single RAM macro port.
//  Round-robin grant with an optional host-priority override. Each grant is held for exactly one transfer.
//  A watchdog terminates any slave cycle that never acks, so neither master can hang.
// PARAMETERS
//  ADDR_W   10   word address width (RAM depth 2**ADDR_W x 32b)
//  DATA_W   32   data width
//  SEL_W    4    byte-select width (DATA_W/8)
//  TMO      255  slave-ack timeout in cycles (>=2); counter width $clog2(TMO+1)
// PORTS
//  clock          in   1       single clock
//  reset          in   1       synchronous, active-high
//  prio_host      in   1       1: M1 wins simultaneous requests; 0: round-robin
//  m0_cyc/m0_stb  in   1/1     core request
//  m0_we          in   1       core write enable
//  m0_adr         in   ADDR_W  core word address
//  m0_dat_w       in   DATA_W  core write data
//  m0_sel         in   SEL_W   core byte selects
//  m0_ack         out  1       core transfer done (1-cycle pulse)
//  m0_err         out  1       core transfer timed out (pulses with m0_ack)
//  m0_dat_r       out  DATA_W  core read data, valid while m0_ack=1
//  m1_*           ---  ---     same set as m0_* for the host master
//  s_cyc/s_stb    out  1/1     slave request
//  s_we           out  1       slave write enable
//  s_adr          out  ADDR_W  slave address
//  s_dat_w        out  DATA_W  slave write data
//  s_sel          out  SEL_W   slave byte selects
//  s_ack          in   1       slave ack
//  s_dat_r        in   DATA_W  slave read data
// BEHAVIOUR
//  Reset values: all outputs 0; state=IDLE; last_gnt=1 (M0 wins the first tie); tmo_cnt=0.
//  Reset mid-transfer aborts it: s_cyc drops the next cycle, and no ack is issued to either master.
//  req_n = mn_cyc & mn_stb.
//  FSM IDLE/BUSY/DONE, all outputs registered.
//  IDLE:
//   - No request: stay in IDLE.
//   - Single request: grant that master.
//   - Both requesting, prio_host=1: grant M1.
//   - Both requesting, prio_host=0: grant the master that is not last_gnt.
//   - On any grant: latch we/adr/dat_w/sel into s_*, set s_cyc=s_stb=1, gnt<=winner, last_gnt<=winner, tmo_cnt<=0, go BUSY.
//  BUSY (s_* held stable):
//   - s_ack=1: s_cyc=s_stb=0; pulse gnt master's ack; capture s_dat_r for reads only (0 on writes); go DONE.
//   - Else if tmo_cnt==TMO-1: drop s_cyc/s_stb; pulse the gnt master's ack with err=1 and dat_r=0; go DONE.
//   - Else tmo_cnt++.
//  DONE: exactly one cycle; mn_ack/mn_err/mn_dat_r visible. Requests are ignored here, so a master has one cycle to drop stb. Then go IDLE.
//  Ack/err/dat_r go to the granted master only; the other master sees 0.
//  Latency: request seen at edge N -> s_stb at N+1; s_ack at edge K -> mn_ack high in cycle K+1.
//  Minimum 3 cycles per transfer, so each master gets at most 1 transfer per 3 cycles.
//  Back-to-back with both masters requesting and prio_host=0: grants alternate M0,M1,M0...
//  A master dropping cyc while BUSY does not cancel the slave cycle; its ack is still pulsed and discarded by the master.
//  s_ack outside BUSY is ignored.
//  prio_host is sampled only in IDLE; a change mid-transfer takes effect from the next arbitration.
// STRUCTURE
//  Package spell_rambus_pkg holds:
//   - state enum {IDLE,BUSY,DONE}
//   - master-index typedef
//   - default TMO constant
//   - timeout read value (0)
//  No sub-modules: a single flat module holding the FSM, the request latch and the timeout counter.
// TESTING
//  1) Reset, then M0 reads adr 0x005 with slave acking 1 cycle after stb, returning 0x1234_5678 -> m0_ack pulse in cycle 3 with m0_dat_r=0x1234_5678; m1_ack stays 0.
//  2) M0 and M1 request continuously, prio_host=0, 6 transfers -> s grant order M0,M1,M0,M1,M0,M1; each master gets 3 acks; no cycle has s_stb=1 for a stale request.
//  3) Same as 2 with prio_host=1 -> all 6 grants to M1; M0 is granted only after M1 drops cyc.
//  4) M1 writes 0xCAFEF00D to adr 0x3FF with sel=4'b0011; slave never acks -> s_stb drops after TMO cycles; m1_ack=m1_err=1 for 1 cycle; m1_dat_r=0; the next M0 request is granted normally.
//  5) Assert reset while BUSY (s_stb=1) -> next cycle all outputs are 0, no ack to either master; a request after reset is served with M0 winning a tie.
//  6) M0 drops cyc while BUSY, then s_ack arrives -> m0_ack still pulses once; the FSM returns through DONE to IDLE with no extra slave cycle.

Source files
------------

// File: rtl/spell_rambus_pkg.sv
// Shared types and constants for the spell RAM bus arbiter.
//   state_t     : arbiter FSM states
//   mst_t       : master index (M0 = spell core, M1 = host window)
//   TMO_DEFAULT : default slave-ack timeout in cycles
//   TMO_RDATA   : read data returned on a timed-out transfer
package spell_rambus_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef enum logic {MST_M0 = 1'b0, MST_M1 = 1'b1} mst_t;

  localparam int unsigned TMO_DEFAULT = 255;
  localparam logic [63:0] TMO_RDATA   = '0;

endpackage

// File: rtl/spell_rambus_arbiter_if.sv
// Signal bundle for the two-master / one-slave Wishbone classic arbiter.
//   m0_* : spell core master link    m1_* : host window master link
//   s_*  : RAM macro slave link
// Modports:
//   slave  : the arbiter's view (accepts master requests, drives the RAM)
//   master : the surrounding agents' view (masters and the RAM response)
interface spell_rambus_arbiter_if
  import spell_rambus_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SEL_W  = 4
);

  logic              m0_cyc, m0_stb, m0_we;
  logic [ADDR_W-1:0] m0_adr;
  logic [DATA_W-1:0] m0_dat_w;
  logic [SEL_W-1:0]  m0_sel;
  logic              m0_ack, m0_err;
  logic [DATA_W-1:0] m0_dat_r;

  logic              m1_cyc, m1_stb, m1_we;
  logic [ADDR_W-1:0] m1_adr;
  logic [DATA_W-1:0] m1_dat_w;
  logic [SEL_W-1:0]  m1_sel;
  logic              m1_ack, m1_err;
  logic [DATA_W-1:0] m1_dat_r;

  logic              s_cyc, s_stb, s_we;
  logic [ADDR_W-1:0] s_adr;
  logic [DATA_W-1:0] s_dat_w;
  logic [SEL_W-1:0]  s_sel;
  logic              s_ack;
  logic [DATA_W-1:0] s_dat_r;

  modport slave (
    input  m0_cyc, m0_stb, m0_we, m0_adr, m0_dat_w, m0_sel,
    output m0_ack, m0_err, m0_dat_r,
    input  m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_w, m1_sel,
    output m1_ack, m1_err, m1_dat_r,
    output s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel,
    input  s_ack, s_dat_r
  );

  modport master (
    output m0_cyc, m0_stb, m0_we, m0_adr, m0_dat_w, m0_sel,
    input  m0_ack, m0_err, m0_dat_r,
    output m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_w, m1_sel,
    input  m1_ack, m1_err, m1_dat_r,
    input  s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel,
    output s_ack, s_dat_r
  );

endinterface

// File: rtl/spell_rambus_arbiter.sv
// Two-master to one-slave Wishbone classic arbiter for the spell RAM bus.
// Round-robin grant with optional host priority, one transfer per grant,
// and a watchdog that ends any slave cycle that never acks.
// Ports:
//   clock     : single clock
//   reset     : synchronous, active-high
//   prio_host : 1 = M1 wins simultaneous requests, 0 = round-robin
//   bus       : m0/m1 master links and s slave link (slave modport)
// All outputs are registered.
module spell_rambus_arbiter
  import spell_rambus_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SEL_W  = 4,
  parameter int unsigned TMO    = TMO_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  prio_host,
  spell_rambus_arbiter_if.slave bus
);

  localparam int unsigned       TW       = $clog2(TMO + 1);
  localparam logic [TW-1:0]     TMO_LAST = TW'(TMO - 1);
  localparam logic [DATA_W-1:0] RD_TMO   = DATA_W'(TMO_RDATA);

  state_t            state_q, state_d;
  mst_t              gnt_q, gnt_d;
  mst_t              last_q, last_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] rdat0_q, rdat0_d;
  logic [DATA_W-1:0] rdat1_q, rdat1_d;

  logic req0, req1;
  mst_t win;

  assign req0 = bus.m0_cyc & bus.m0_stb;
  assign req1 = bus.m1_cyc & bus.m1_stb;

  // On a tie the master that did not win last time goes next, unless host priority is set.
  always_comb begin
    if (req0 && req1) begin
      if (prio_host) win = MST_M1;
      else           win = (last_q == MST_M0) ? MST_M1 : MST_M0;
    end else if (req1) begin
      win = MST_M1;
    end else begin
      win = MST_M0;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    tmo_d   = tmo_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    ack_d   = '0;
    err_d   = '0;
    rdat0_d = '0;
    rdat1_d = '0;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = BUSY;
          gnt_d   = win;
          last_d  = win;
          tmo_d   = '0;
          cyc_d   = 1'b1;
          if (win == MST_M1) begin
            we_d   = bus.m1_we;
            adr_d  = bus.m1_adr;
            wdat_d = bus.m1_dat_w;
            sel_d  = bus.m1_sel;
          end else begin
            we_d   = bus.m0_we;
            adr_d  = bus.m0_adr;
            wdat_d = bus.m0_dat_w;
            sel_d  = bus.m0_sel;
          end
        end
      end

      BUSY: begin
        if (bus.s_ack) begin
          state_d      = DONE;
          cyc_d        = 1'b0;
          ack_d[gnt_q] = 1'b1;
          if (gnt_q == MST_M1) rdat1_d = we_q ? '0 : bus.s_dat_r;
          else                 rdat0_d = we_q ? '0 : bus.s_dat_r;
        end else if (tmo_q == TMO_LAST) begin
          state_d      = DONE;
          cyc_d        = 1'b0;
          ack_d[gnt_q] = 1'b1;
          err_d[gnt_q] = 1'b1;
          if (gnt_q == MST_M1) rdat1_d = RD_TMO;
          else                 rdat0_d = RD_TMO;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= MST_M0;
      last_q  <= MST_M1;
      tmo_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      rdat0_q <= '0;
      rdat1_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat0_q <= rdat0_d;
      rdat1_q <= rdat1_d;
    end
  end

  assign bus.s_cyc    = cyc_q;
  assign bus.s_stb    = cyc_q;
  assign bus.s_we     = we_q;
  assign bus.s_adr    = adr_q;
  assign bus.s_dat_w  = wdat_q;
  assign bus.s_sel    = sel_q;
  assign bus.m0_ack   = ack_q[0];
  assign bus.m1_ack   = ack_q[1];
  assign bus.m0_err   = err_q[0];
  assign bus.m1_err   = err_q[1];
  assign bus.m0_dat_r = rdat0_q;
  assign bus.m1_dat_r = rdat1_q;

endmodule

// File: tb/tb_spell_rambus_arbiter.sv
// Self-checking bench for spell_rambus_arbiter: directed steps plus randomized
// transfer mixes checked against a transaction-level model of the arbiter.
module tb_spell_rambus_arbiter;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned TMO    = 12;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat;
    logic [SEL_W-1:0]  sel;
  } txn_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic prio_host = 1'b0;

  always #5 clock = ~clock;

  spell_rambus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)) bus();

  spell_rambus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W), .TMO(TMO)) dut (
    .clock     (clock),
    .reset     (reset),
    .prio_host (prio_host),
    .bus       (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned mdl_last = 1;

  logic [DATA_W-1:0] ram     [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];

  // RAM responder
  logic              rsp_ack = 1'b0;
  logic              spur_ack = 1'b0;
  logic [DATA_W-1:0] rsp_dat = '0;
  bit                slave_mute = 1'b0;
  bit                lat_rand = 1'b1;
  int unsigned       fixed_lat = 0;
  bit                rsp_busy = 1'b0;
  int unsigned       rsp_wait = 0;
  int unsigned       rsp_lat = 0;

  assign bus.s_ack   = rsp_ack | spur_ack;
  assign bus.s_dat_r = rsp_dat;

  always @(posedge clock) begin
    #1;
    rsp_dat = $urandom;
    rsp_ack = 1'b0;
    if (bus.s_cyc === 1'b1 && bus.s_stb === 1'b1 && !slave_mute) begin
      if (!rsp_busy) begin
        rsp_busy = 1'b1;
        rsp_wait = 0;
        rsp_lat  = lat_rand ? $urandom_range(3, 0) : fixed_lat;
      end
      if (rsp_wait == rsp_lat) begin
        rsp_ack = 1'b1;
        if (bus.s_we) begin
          for (int b = 0; b < SEL_W; b++)
            if (bus.s_sel[b]) ram[bus.s_adr][8*b +: 8] = bus.s_dat_w[8*b +: 8];
        end else begin
          rsp_dat = ram[bus.s_adr];
        end
      end
      rsp_wait++;
    end else begin
      rsp_busy = 1'b0;
    end
  end

  // Grant monitor: every slave cycle start, recorded by address
  logic [ADDR_W-1:0] grants[$];
  bit stb_prev = 1'b0;

  always @(negedge clock) begin
    if (bus.s_stb === 1'b1 && !stb_prev) grants.push_back(bus.s_adr);
    stb_prev = (bus.s_stb === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic outs_any();
    return |{bus.s_cyc, bus.s_stb, bus.s_we, bus.s_adr, bus.s_dat_w, bus.s_sel,
             bus.m0_ack, bus.m0_err, bus.m0_dat_r, bus.m1_ack, bus.m1_err, bus.m1_dat_r};
  endfunction

  task automatic drive(input int unsigned m, input logic v, input txn_t t);
    if (m == 0) begin
      bus.m0_cyc = v; bus.m0_stb = v; bus.m0_we = t.we;
      bus.m0_adr = t.adr; bus.m0_dat_w = t.dat; bus.m0_sel = t.sel;
    end else begin
      bus.m1_cyc = v; bus.m1_stb = v; bus.m1_we = t.we;
      bus.m1_adr = t.adr; bus.m1_dat_w = t.dat; bus.m1_sel = t.sel;
    end
  endtask

  // M0 works in the lower half of the RAM, M1 in the upper half
  function automatic txn_t rnd_txn(input int unsigned m);
    txn_t t;
    t.we  = 1'($urandom_range(1, 0));
    t.adr = ADDR_W'(m * 512 + $urandom_range(511, 0));
    t.dat = $urandom;
    t.sel = SEL_W'($urandom_range(15, 0));
    return t;
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old, input txn_t t);
    logic [DATA_W-1:0] r;
    r = old;
    for (int b = 0; b < SEL_W; b++)
      if (t.sel[b]) r[8*b +: 8] = t.dat[8*b +: 8];
    return r;
  endfunction

  task automatic check_ack(input int unsigned m, input txn_t t, input string tag);
    logic [DATA_W-1:0] exp_d;
    exp_d = t.we ? '0 : ref_mem[t.adr];
    if (m == 0) begin
      chk({tag, "_m0_err"},   bus.m0_err,   0);
      chk({tag, "_m0_dat"},   bus.m0_dat_r, exp_d);
      chk({tag, "_m1_quiet"}, {bus.m1_ack, bus.m1_dat_r}, 0);
    end else begin
      chk({tag, "_m1_err"},   bus.m1_err,   0);
      chk({tag, "_m1_dat"},   bus.m1_dat_r, exp_d);
      chk({tag, "_m0_quiet"}, {bus.m0_ack, bus.m0_dat_r}, 0);
    end
    if (t.we) ref_mem[t.adr] = merge(ref_mem[t.adr], t);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    mdl_last = 1;
  endtask

  // Both masters present their queued transfers back to back; the expected
  // grant order comes from the arbitration rules applied per transfer.
  task automatic run_pair(input int unsigned n0, input int unsigned n1, input logic prio, input string tag);
    txn_t q0[$];
    txn_t q1[$];
    logic [ADDR_W-1:0] exp_g[$];
    int unsigned a, b, w, acks0, acks1, budget;
    for (int i = 0; i < int'(n0); i++) q0.push_back(rnd_txn(0));
    for (int i = 0; i < int'(n1); i++) q1.push_back(rnd_txn(1));
    a = 0; b = 0;
    while (a < n0 || b < n1) begin
      if (a < n0 && b < n1) w = prio ? 1 : ((mdl_last == 0) ? 1 : 0);
      else                  w = (a < n0) ? 0 : 1;
      if (w == 0) begin exp_g.push_back(q0[a].adr); a++; end
      else        begin exp_g.push_back(q1[b].adr); b++; end
      mdl_last = w;
    end

    grants.delete();
    prio_host  = prio;
    lat_rand   = 1'b1;
    slave_mute = 1'b0;
    acks0 = 0; acks1 = 0;
    if (q0.size() != 0) drive(0, 1'b1, q0[0]); else drive(0, 1'b0, '0);
    if (q1.size() != 0) drive(1, 1'b1, q1[0]); else drive(1, 1'b0, '0);
    budget = 20 * (n0 + n1) + 10;
    for (int c = 0; c < int'(budget) && (q0.size() + q1.size()) != 0; c++) begin
      @(posedge clock);
      #1;
      if (bus.m0_ack === 1'b1) begin
        acks0++;
        if (q0.size() == 0) chk({tag, "_m0_extra_ack"}, bus.m0_ack, 0);
        else begin
          check_ack(0, q0[0], tag);
          void'(q0.pop_front());
          if (q0.size() != 0) drive(0, 1'b1, q0[0]); else drive(0, 1'b0, '0);
        end
      end
      if (bus.m1_ack === 1'b1) begin
        acks1++;
        if (q1.size() == 0) chk({tag, "_m1_extra_ack"}, bus.m1_ack, 0);
        else begin
          check_ack(1, q1[0], tag);
          void'(q1.pop_front());
          if (q1.size() != 0) drive(1, 1'b1, q1[0]); else drive(1, 1'b0, '0);
        end
      end
    end
    chk({tag, "_drained"}, q0.size() + q1.size(), 0);
    repeat (2) @(posedge clock);
    #1;
    chk({tag, "_m0_acks"}, acks0, n0);
    chk({tag, "_m1_acks"}, acks1, n1);
    chk({tag, "_ngrants"}, grants.size(), exp_g.size());
    for (int i = 0; i < exp_g.size() && i < grants.size(); i++)
      chk($sformatf("%s_grant%0d", tag, i), grants[i], exp_g[i]);
  endtask

  initial begin
    txn_t t;

    for (int i = 0; i < (1 << ADDR_W); i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end

    // Reset state
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_outputs", outs_any(), 0);
    reset = 1'b0;
    mdl_last = 1;

    // 1) M0 read of 0x005, slave acks one cycle after stb
    ram[5]     = 32'h1234_5678;
    ref_mem[5] = 32'h1234_5678;
    lat_rand   = 1'b0;
    fixed_lat  = 1;
    t.we = 1'b0; t.adr = 10'h005; t.dat = $urandom; t.sel = 4'hF;
    drive(0, 1'b1, t);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clock);
      #1;
      chk($sformatf("t1_stb_c%0d", c), bus.s_stb, (c == 1 || c == 2));
      chk($sformatf("t1_m0ack_c%0d", c), bus.m0_ack, (c == 3));
      chk($sformatf("t1_m0dat_c%0d", c), bus.m0_dat_r, (c == 3) ? 32'h1234_5678 : 32'h0);
      chk($sformatf("t1_m1ack_c%0d", c), bus.m1_ack, 0);
      if (c == 1) chk("t1_sadr", {bus.s_we, bus.s_adr}, {1'b0, 10'h005});
      if (c == 3) drive(0, 1'b0, t);
    end
    mdl_last = 0;

    // Stray slave ack while idle
    spur_ack = 1'b1;
    @(posedge clock);
    #1;
    spur_ack = 1'b0;
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("spur_quiet_c%0d", c),
          {bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err, bus.s_stb}, 0);
      @(posedge clock);
      #1;
    end

    // 2) Both request continuously, round-robin
    do_reset();
    run_pair(3, 3, 1'b0, "t2");

    // 3) Both request continuously, host priority
    do_reset();
    run_pair(3, 6, 1'b1, "t3");

    // 4) M1 write never acked -> timeout
    prio_host  = 1'b0;
    slave_mute = 1'b1;
    t.we = 1'b1; t.adr = 10'h3FF; t.dat = 32'hCAFE_F00D; t.sel = 4'b0011;
    drive(1, 1'b1, t);
    for (int c = 1; c <= int'(TMO) + 2; c++) begin
      @(posedge clock);
      #1;
      chk($sformatf("t4_stb_c%0d", c), bus.s_stb, (c <= int'(TMO)));
      chk($sformatf("t4_m1ack_c%0d", c), bus.m1_ack, (c == int'(TMO) + 1));
      chk($sformatf("t4_m1err_c%0d", c), bus.m1_err, (c == int'(TMO) + 1));
      chk($sformatf("t4_m1dat_c%0d", c), bus.m1_dat_r, 0);
      chk($sformatf("t4_m0ack_c%0d", c), bus.m0_ack, 0);
      if (c == 1)
        chk("t4_sreq", {bus.s_we, bus.s_adr, bus.s_dat_w, bus.s_sel},
            {1'b1, 10'h3FF, 32'hCAFE_F00D, 4'b0011});
      if (c == int'(TMO) + 1) drive(1, 1'b0, t);
    end
    mdl_last = 1;
    slave_mute = 1'b0;
    run_pair(1, 0, 1'b0, "t4_next");

    // 5) Reset while a slave cycle is open
    slave_mute = 1'b1;
    t = rnd_txn(0);
    drive(0, 1'b1, t);
    @(posedge clock);
    #1;
    chk("t5_stb_open", bus.s_stb, 1);
    reset = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clock);
      #1;
      chk($sformatf("t5_rst_outs_c%0d", c), outs_any(), 0);
    end
    drive(0, 1'b0, t);
    reset = 1'b0;
    mdl_last = 1;
    slave_mute = 1'b0;
    run_pair(1, 1, 1'b0, "t5_tie");

    // 6) M0 abandons its request while the slave is still working
    lat_rand  = 1'b0;
    fixed_lat = 3;
    t = rnd_txn(0);
    t.we = 1'b0;
    grants.delete();
    drive(0, 1'b1, t);
    @(posedge clock);
    #1;
    chk("t6_stb_open", bus.s_stb, 1);
    drive(0, 1'b0, t);
    begin
      int unsigned acks;
      acks = 0;
      for (int c = 0; c < 12; c++) begin
        @(posedge clock);
        #1;
        if (bus.m0_ack === 1'b1) begin
          acks++;
          check_ack(0, t, "t6");
        end
      end
      chk("t6_m0_acks", acks, 1);
    end
    chk("t6_ngrants", grants.size(), 1);
    chk("t6_stb_idle", bus.s_stb, 0);
    mdl_last = 0;

    // Random mixes
    for (int r = 0; r < 4; r++)
      run_pair($urandom_range(4, 1), $urandom_range(4, 1), 1'($urandom_range(1, 0)),
               $sformatf("rnd%0d", r));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
